flash_ctrl: RTL and testbench
=============================

# flash_ctrl

Parametrised controller for the on-board parallel NOR flash (Intel StrataFlash command set, 8-bit byte mode). It sits between the scoreboard logic and the `NF_*` pins. It turns a single-cycle request into fully timed read, program or block-erase bus sequences. Internal wait-state counters replace the external timer, and it handles RP# power-up, STS polling, status-register checking and the return to read-array mode.

## Interface
- `AW`, 24: address width.
- `DW`, 8: data width (8 for byte mode; status bits are taken from `[7:0]`).
- `RD_WAIT`, 4: cycles CE#/OE# are held low before read data is sampled (≥1).
- `WR_PULSE`, 3: cycles WE# is held low per bus write (≥1).
- `RP_WAIT`, 16: cycles after RP# release before the first request is accepted.
- `TO_CYC`, 2_000_000: STS busy timeout in cycles.
- `clk_f` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: start operation; sampled only when `busy`=0.
- `cmd` in 2: 00 read, 01 program, 10 block erase, 11 reserved (treated as error).
- `addr` in AW: byte address.
- `wdata` in DW: program data.
- `rdata` out DW: read result; holds its value until the next read.
- `busy` out 1: high from `req` acceptance (and during power-up) until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; cleared on the next accept.
- `NF_A` out AW, `NF_D_O` out DW, `NF_D_OE` out 1 (top-level tristate enable), `NF_D_I` in DW.
- `NF_CE`, `NF_OE`, `NF_WE`, `NF_RP` out 1 (active-low); `NF_BYTE`, `NF_WP` out 1 (tied 0); `NF_STS` in 1 (0 = device busy).

## Operation
- `NF_STS` is passed through a 2-flop synchroniser.
- `addr`, `wdata` and `cmd` are latched on accept.
- States: PWR, IDLE, RD, BW (bus write), STS, SR, DONE.
- **PWR:** `NF_RP`=0 while `rst` is high. Afterwards `NF_RP`=1, then `RP_WAIT` cycles with `busy`=1, then IDLE.
- **Read:** RD with CE#=OE#=0 for `RD_WAIT` cycles. `rdata` is captured at the last edge, then DONE.
- **Bus write** (BW sub-phases):
  - setup, 1 cycle: CE#=0, `NF_D_OE`=1.
  - pulse, `WR_PULSE` cycles: WE#=0.
  - hold, 1 cycle: WE#=1, data still driven.
  - recovery, 1 cycle: CE#=1, `NF_D_OE`=0.
- **Program:** BW 0x40 → BW `wdata` → STS → SR → [BW 0x50 if error] → BW 0xFF → DONE.
- **Erase:** BW 0x20 → BW 0xD0, then the same tail as program.
- **STS state:** ignores the synchronised STS for its first 2 cycles. It then waits for STS=1. If `TO_CYC` expires first, `err` is set and SR is skipped.
- **SR state:** a read cycle identical to RD, with its result internal.
  - Error if SR bit 5, 4, 3 or 1 is set.
  - SR bit 7 = 0 here is also an error.
- **Reserved `cmd`:** → DONE the next cycle with `err`=1, no bus activity.
- `NF_A` is driven with the latched address during all bus cycles and holds otherwise.
- OE# and WE# are never low simultaneously; OE#=1 whenever `NF_D_OE`=1.

## Timing
- **Reset values:**
  - `NF_CE`=`NF_OE`=`NF_WE`=1, `NF_RP`=0, `NF_D_OE`=0.
  - `NF_D_O`=0, `NF_A`=0.
  - `rdata`=0, `done`=0, `err`=0, `busy`=1.
- **Read:** `req` accepted at edge 0, CE#/OE# low in cycles 1..`RD_WAIT`, `done` high in cycle `RD_WAIT`+1 with strobes already high.
- **Bus write:** occupies `WR_PULSE`+3 cycles; consecutive bus writes are back-to-back.
- **Return to IDLE:** after DONE the block returns to IDLE at the next edge. `req` in the DONE cycle is ignored, as is `req` while `busy`=1 (no queue).
- **Reset mid-operation:** within one edge all strobes go high, `NF_D_OE`=0 and `NF_RP`=0, with no `done` pulse. PWR restarts.

## Configuration
- `FLASH_ERASE_EN` defined: `cmd`=10 performs block erase as above.
- Without it: erase states and constants are not compiled, and `cmd`=10 behaves as reserved (`done` + `err` after one cycle, no bus activity).

## Test plan
- **Power-up:** release `rst`. `NF_RP` rises 1 cycle later; `busy` falls exactly `RP_WAIT` cycles after that, and no strobe toggles.
- **Read:** read `addr`=0x000123 with the flash model returning 0x5A. `NF_OE` is low for 4 cycles, then `done` with `rdata`=0x5A and `err`=0.
- **Program:** program 0xA5 at 0x000010 with STS low for 50 cycles and SR=0x80.
  - Required bus sequence: writes 0x40, 0xA5, an SR read, then 0xFF.
  - WE# is low 3 cycles each; `done` then fires with `err`=0.
- **Program error:** SR=0x90. The bus sequence includes a 0x50 write before 0xFF; `err`=1 with `done`.
- **Timeout / erase:** use `TO_CYC`=100 with STS held at 0.
  - Required: `err`=1 and a final 0xFF write.
  - Erase `cmd`=10: with the macro, 0x20/0xD0 appear on the bus; without it, `done`+`err` follow in 1 cycle with no strobes.
- **Abort:** assert `rst` during a WE# pulse. Next cycle WE#=CE#=1, `NF_D_OE`=0 and `NF_RP`=0; no `done` pulse.

Source files
------------

// File: rtl/flash_ctrl.sv
// ---------------------------------------------------------------------------
// flash_ctrl
//   Controller for a parallel NOR flash (StrataFlash command set, byte mode).
//   Converts a single-cycle request into timed read, program or block-erase
//   bus sequences, including RP# power-up wait, STS polling with timeout,
//   status-register check, error clear and return to read-array mode.
//
//   Optional feature macro: FLASH_ERASE_EN
//     defined   -> cmd 2'b10 performs a block erase (0x20 / 0xD0).
//     undefined -> cmd 2'b10 is treated as reserved (done + err, no bus).
//
// Ports
//   clk_f, rst          : clock (rising edge), synchronous active-high reset
//   req, cmd, addr,     : request handshake (sampled when idle), operation
//   wdata                 code (00 read, 01 program, 10 erase, 11 reserved),
//                         byte address and program data
//   rdata, busy, done,  : read result, busy flag, 1-cycle completion pulse,
//   err                   error flag valid with done
//   NF_A, NF_D_O,       : flash address, write data, data output enable,
//   NF_D_OE, NF_D_I       read data
//   NF_CE, NF_OE, NF_WE,: active-low strobes and reset/power-down
//   NF_RP
//   NF_BYTE, NF_WP      : tied low
//   NF_STS              : device status (0 = busy), asynchronous
// ---------------------------------------------------------------------------
module flash_ctrl #(
    parameter int AW       = 24,
    parameter int DW       = 8,
    parameter int RD_WAIT  = 4,
    parameter int WR_PULSE = 3,
    parameter int RP_WAIT  = 16,
    parameter int TO_CYC   = 2_000_000
) (
    input  logic          clk_f,
    input  logic          rst,
    input  logic          req,
    input  logic [1:0]    cmd,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] NF_A,
    output logic [DW-1:0] NF_D_O,
    output logic          NF_D_OE,
    input  logic [DW-1:0] NF_D_I,
    output logic          NF_CE,
    output logic          NF_OE,
    output logic          NF_WE,
    output logic          NF_RP,
    output logic          NF_BYTE,
    output logic          NF_WP,
    input  logic          NF_STS
);

    localparam int CW = $clog2(TO_CYC + RP_WAIT + RD_WAIT + WR_PULSE + 2);

    localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WP_LAST = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(RP_WAIT - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] STS_IGN = CW'(2);

    localparam logic [DW-1:0] CB_PROG    = DW'(8'h40);
    localparam logic [DW-1:0] CB_CLR     = DW'(8'h50);
    localparam logic [DW-1:0] CB_RA      = DW'(8'hFF);
`ifdef FLASH_ERASE_EN
    localparam logic [DW-1:0] CB_ERASE   = DW'(8'h20);
    localparam logic [DW-1:0] CB_CONFIRM = DW'(8'hD0);
`endif

    typedef enum logic [2:0] {
        ST_PWR, ST_IDLE, ST_RD, ST_BW, ST_STS, ST_SR, ST_DONE
    } state_t;

    // Bus-write sub-phase; PH_GAP is one idle cycle inserted after the
    // status read so the write's CE# falling edge is distinct.
    typedef enum logic [2:0] {
        PH_SETUP, PH_PULSE, PH_HOLD, PH_REC, PH_GAP
    } phase_t;

    // Which write of the sequence is in flight.
    typedef enum logic [1:0] {
        SQ_CMD1, SQ_CMD2, SQ_CLR, SQ_RA
    } seq_t;

    state_t        state_r;
    phase_t        phase_r;
    seq_t          seq_r;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] byte1_r;    // first written byte (setup command)
    logic [DW-1:0] wdata_r;    // second written byte (data or confirm)
    logic          sts_meta_r;
    logic          sts_sync_r;

    // Data byte to drive for a given write of the sequence.
    function automatic logic [DW-1:0] wr_byte(input seq_t sq,
                                              input logic [DW-1:0] b1,
                                              input logic [DW-1:0] wd);
        case (sq)
            SQ_CMD1: wr_byte = b1;
            SQ_CMD2: wr_byte = wd;
            SQ_CLR:  wr_byte = CB_CLR;
            SQ_RA:   wr_byte = CB_RA;
            default: wr_byte = CB_RA;
        endcase
    endfunction

    // Status-register failure: bits {7,5,4,3,1}; ready bit 7 must be set.
    function automatic logic sr_err(input logic [4:0] b);
        sr_err = ~b[4] | b[3] | b[2] | b[1] | b[0];
    endfunction

    assign NF_BYTE = 1'b0;
    assign NF_WP   = 1'b0;

    // Main controller FSM, STS synchroniser and all registered outputs.
    always_ff @(posedge clk_f) begin
        if (rst) begin
            state_r    <= ST_PWR;
            phase_r    <= PH_SETUP;
            seq_r      <= SQ_CMD1;
            cnt_r      <= '0;
            byte1_r    <= CB_PROG;
            wdata_r    <= '0;
            sts_meta_r <= 1'b0;
            sts_sync_r <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            NF_A       <= '0;
            NF_D_O     <= '0;
            NF_D_OE    <= 1'b0;
            NF_CE      <= 1'b1;
            NF_OE      <= 1'b1;
            NF_WE      <= 1'b1;
            NF_RP      <= 1'b0;
        end else begin
            sts_meta_r <= NF_STS;
            sts_sync_r <= sts_meta_r;
            done       <= 1'b0;
            case (state_r)
                ST_PWR: begin
                    if (!NF_RP) begin
                        NF_RP <= 1'b1;
                        cnt_r <= '0;
                    end else if (cnt_r == RP_LAST) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        cnt_r   <= '0;
                        wdata_r <= wdata;
                        byte1_r <= CB_PROG;
                        case (cmd)
                            2'b00: begin
                                NF_A    <= addr;
                                NF_CE   <= 1'b0;
                                NF_OE   <= 1'b0;
                                state_r <= ST_RD;
                            end
                            2'b01: begin
                                NF_A    <= addr;
                                NF_CE   <= 1'b0;
                                NF_D_OE <= 1'b1;
                                NF_D_O  <= CB_PROG;
                                seq_r   <= SQ_CMD1;
                                phase_r <= PH_SETUP;
                                state_r <= ST_BW;
                            end
`ifdef FLASH_ERASE_EN
                            2'b10: begin
                                NF_A    <= addr;
                                byte1_r <= CB_ERASE;
                                wdata_r <= CB_CONFIRM;
                                NF_CE   <= 1'b0;
                                NF_D_OE <= 1'b1;
                                NF_D_O  <= CB_ERASE;
                                seq_r   <= SQ_CMD1;
                                phase_r <= PH_SETUP;
                                state_r <= ST_BW;
                            end
`endif
                            default: begin
                                done    <= 1'b1;
                                err     <= 1'b1;
                                state_r <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_RD: begin
                    if (cnt_r == RD_LAST) begin
                        rdata   <= NF_D_I;
                        NF_CE   <= 1'b1;
                        NF_OE   <= 1'b1;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_BW: begin
                    case (phase_r)
                        PH_SETUP: begin
                            NF_WE   <= 1'b0;
                            cnt_r   <= '0;
                            phase_r <= PH_PULSE;
                        end
                        PH_PULSE: begin
                            if (cnt_r == WP_LAST) begin
                                NF_WE   <= 1'b1;
                                phase_r <= PH_HOLD;
                            end else begin
                                cnt_r <= cnt_r + CW'(1);
                            end
                        end
                        PH_HOLD: begin
                            NF_CE   <= 1'b1;
                            NF_D_OE <= 1'b0;
                            phase_r <= PH_REC;
                        end
                        PH_REC: begin
                            case (seq_r)
                                SQ_CMD1: begin
                                    NF_CE   <= 1'b0;
                                    NF_D_OE <= 1'b1;
                                    NF_D_O  <= wr_byte(SQ_CMD2, byte1_r, wdata_r);
                                    seq_r   <= SQ_CMD2;
                                    phase_r <= PH_SETUP;
                                end
                                SQ_CMD2: begin
                                    cnt_r   <= '0;
                                    state_r <= ST_STS;
                                end
                                SQ_CLR: begin
                                    NF_CE   <= 1'b0;
                                    NF_D_OE <= 1'b1;
                                    NF_D_O  <= wr_byte(SQ_RA, byte1_r, wdata_r);
                                    seq_r   <= SQ_RA;
                                    phase_r <= PH_SETUP;
                                end
                                SQ_RA: begin
                                    done    <= 1'b1;
                                    state_r <= ST_DONE;
                                end
                                default: begin
                                    done    <= 1'b1;
                                    err     <= 1'b1;
                                    state_r <= ST_DONE;
                                end
                            endcase
                        end
                        PH_GAP: begin
                            NF_CE   <= 1'b0;
                            NF_D_OE <= 1'b1;
                            NF_D_O  <= wr_byte(seq_r, byte1_r, wdata_r);
                            phase_r <= PH_SETUP;
                        end
                        default: begin
                            NF_WE   <= 1'b1;
                            phase_r <= PH_REC;
                        end
                    endcase
                end
                ST_STS: begin
                    // STS may still show the pre-write ready level right
                    // after the write, so the first cycles are ignored.
                    if (cnt_r < STS_IGN) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else if (sts_sync_r) begin
                        NF_CE   <= 1'b0;
                        NF_OE   <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= ST_SR;
                    end else if (cnt_r >= TO_LAST) begin
                        err     <= 1'b1;
                        NF_CE   <= 1'b0;
                        NF_D_OE <= 1'b1;
                        NF_D_O  <= CB_RA;
                        seq_r   <= SQ_RA;
                        phase_r <= PH_SETUP;
                        state_r <= ST_BW;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_SR: begin
                    if (cnt_r == RD_LAST) begin
                        NF_CE   <= 1'b1;
                        NF_OE   <= 1'b1;
                        phase_r <= PH_GAP;
                        state_r <= ST_BW;
                        if (sr_err({NF_D_I[7], NF_D_I[5], NF_D_I[4], NF_D_I[3], NF_D_I[1]})) begin
                            err   <= 1'b1;
                            seq_r <= SQ_CLR;
                        end else begin
                            seq_r <= SQ_RA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    NF_CE   <= 1'b1;
                    NF_OE   <= 1'b1;
                    NF_WE   <= 1'b1;
                    NF_D_OE <= 1'b0;
                    NF_RP   <= 1'b0;
                    busy    <= 1'b1;
                    state_r <= ST_PWR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_ctrl.sv
module tb_flash_ctrl;

    localparam int AW       = 24;
    localparam int DW       = 8;
    localparam int RD_WAIT  = 4;
    localparam int WR_PULSE = 3;
    localparam int RP_WAIT  = 16;
    localparam int TO_CYC   = 100;

    logic          clk_f = 1'b0;
    logic          rst   = 1'b1;
    logic          req   = 1'b0;
    logic [1:0]    cmd   = 2'b00;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          busy, done, err;
    logic [AW-1:0] NF_A;
    logic [DW-1:0] NF_D_O;
    logic          NF_D_OE;
    logic [DW-1:0] nf_d_i = '0;
    logic          NF_CE, NF_OE, NF_WE, NF_RP, NF_BYTE, NF_WP;
    logic          nf_sts = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [8:0] log_q[$];
    int   we_bad  = 0;
    int   overlap = 0;
    int   sts_cnt = 0;
    bit   sts_stuck = 1'b0;
    int   strobe_cycles;
    int   oe_cycles;

    flash_ctrl #(
        .AW(AW), .DW(DW), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE),
        .RP_WAIT(RP_WAIT), .TO_CYC(TO_CYC)
    ) dut (
        .clk_f(clk_f), .rst(rst), .req(req), .cmd(cmd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .NF_A(NF_A), .NF_D_O(NF_D_O), .NF_D_OE(NF_D_OE), .NF_D_I(nf_d_i),
        .NF_CE(NF_CE), .NF_OE(NF_OE), .NF_WE(NF_WE), .NF_RP(NF_RP),
        .NF_BYTE(NF_BYTE), .NF_WP(NF_WP), .NF_STS(nf_sts)
    );

    initial forever #5 clk_f = ~clk_f;

    // Flash bus monitor and STS model: logs writes (on WE# rise) and reads
    // (on OE# rise), measures WE# pulse width, and holds STS low for 50
    // cycles after the second write of a program/erase sequence.
    initial begin
        int         we_len;
        logic       prev_we, prev_oe;
        logic [7:0] last_wr;
        we_len  = 0;
        prev_we = 1'b1;
        prev_oe = 1'b1;
        last_wr = 8'h00;
        forever begin
            @(negedge clk_f);
            if (!NF_WE) we_len++;
            if (!prev_we && NF_WE) begin
                log_q.push_back({1'b0, NF_D_O});
                if (we_len != WR_PULSE) we_bad++;
                if (last_wr == 8'h40 || last_wr == 8'h20) sts_cnt = 50;
                last_wr = NF_D_O;
                we_len  = 0;
            end
            if (!prev_oe && NF_OE) log_q.push_back(9'h100);
            if (!NF_OE && (!NF_WE || NF_D_OE)) overlap++;
            if (sts_cnt > 0) sts_cnt--;
            nf_sts  = sts_stuck ? 1'b0 : (sts_cnt == 0);
            prev_we = NF_WE;
            prev_oe = NF_OE;
        end
    end

    function automatic logic [48:0] pack_log();
        logic [48:0] p;
        p = '0;
        p[48:45] = 4'(log_q.size());
        for (int i = 0; i < 5; i++)
            if (i < log_q.size()) p[44 - 9*i -: 9] = log_q[i];
        return p;
    endfunction

    // Issue one request and wait (bounded) for done; done_cyc = -1 on timeout.
    task automatic run_op(input logic [1:0] c, input logic [23:0] a,
                          input logic [7:0] d, input int max_cyc,
                          output int done_cyc);
        done_cyc = -1;
        strobe_cycles = 0;
        oe_cycles = 0;
        log_q.delete();
        @(negedge clk_f);
        cmd = c; addr = a; wdata = d; req = 1'b1;
        @(negedge clk_f);
        req = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (!NF_CE || !NF_OE || !NF_WE) strobe_cycles++;
            if (!NF_OE) oe_cycles++;
            if (done) begin
                done_cyc = k;
                break;
            end
            @(negedge clk_f);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_f);
        checks++;
        if ({NF_CE, NF_OE, NF_WE, NF_RP, NF_D_OE, done, err, busy} !== 8'b1110_0001) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {NF_CE, NF_OE, NF_WE, NF_RP, NF_D_OE, done, err, busy}, 8'b1110_0001);
        end
        checks++;
        if ({NF_A, NF_D_O, rdata, NF_BYTE, NF_WP} !== 42'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {NF_A, NF_D_O, rdata, NF_BYTE, NF_WP});
        end
    endtask

    task automatic test_powerup();
        int rp_k, busy_k, toggles;
        rp_k = -1; busy_k = -1; toggles = 0;
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_f);
            if (!NF_CE || !NF_OE || !NF_WE) toggles++;
            if (rp_k < 0 && NF_RP) rp_k = k;
            if (busy_k < 0 && !busy) begin
                busy_k = k;
                break;
            end
        end
        checks++;
        if (rp_k !== 1) begin
            failures++;
            $display("FAIL pwr_rp_rise got=%0d exp=1", rp_k);
        end
        checks++;
        if (busy_k !== 1 + RP_WAIT) begin
            failures++;
            $display("FAIL pwr_busy_fall got=%0d exp=%0d", busy_k, 1 + RP_WAIT);
        end
        checks++;
        if (toggles !== 0) begin
            failures++;
            $display("FAIL pwr_strobes got=%0d exp=0", toggles);
        end
    endtask

    task automatic test_read();
        int dc;
        nf_d_i = 8'h5A;
        run_op(2'b00, 24'h000123, 8'h00, 20, dc);
        checks++;
        if (dc !== RD_WAIT + 1) begin
            failures++;
            $display("FAIL read_done_cycle got=%0d exp=%0d", dc, RD_WAIT + 1);
        end
        checks++;
        if (oe_cycles !== RD_WAIT) begin
            failures++;
            $display("FAIL read_oe_low got=%0d exp=%0d", oe_cycles, RD_WAIT);
        end
        checks++;
        if ({rdata, err, NF_CE, NF_OE, NF_A} !== {8'h5A, 1'b0, 1'b1, 1'b1, 24'h000123}) begin
            failures++;
            $display("FAIL read_result got=%h exp=%h",
                     {rdata, err, NF_CE, NF_OE, NF_A}, {8'h5A, 1'b0, 1'b1, 1'b1, 24'h000123});
        end
    endtask

    task automatic test_req_ignore();
        int dk, extra;
        dk = -1; extra = 0;
        @(negedge clk_f);
        cmd = 2'b00; addr = 24'h000055; nf_d_i = 8'h11; req = 1'b1;
        @(negedge clk_f);
        cmd = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                dk = k;
                break;
            end
            @(negedge clk_f);
        end
        checks++;
        if ({dk, rdata, err} !== {32'(RD_WAIT + 1), 8'h11, 1'b0}) begin
            failures++;
            $display("FAIL busy_req_ignored got=%0d/%h/%b exp=%0d/11/0", dk, rdata, err, RD_WAIT + 1);
        end
        @(negedge clk_f);
        req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy) extra++;
            @(negedge clk_f);
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL done_req_ignored got=%0d exp=0", extra);
        end
    endtask

    task automatic test_program();
        int dc;
        nf_d_i = 8'h80;
        run_op(2'b01, 24'h000010, 8'hA5, 400, dc);
        checks++;
        if (pack_log() !== {4'd4, 9'h040, 9'h0A5, 9'h100, 9'h0FF, 9'h000}) begin
            failures++;
            $display("FAIL prog_bus_seq got=%h exp=%h", pack_log(),
                     {4'd4, 9'h040, 9'h0A5, 9'h100, 9'h0FF, 9'h000});
        end
        checks++;
        if ({dc > 0, err, NF_A} !== {1'b1, 1'b0, 24'h000010}) begin
            failures++;
            $display("FAIL prog_done got=%0d/%b/%h exp=done/0/000010", dc, err, NF_A);
        end
        checks++;
        if ({we_bad, overlap} !== 64'd0) begin
            failures++;
            $display("FAIL prog_strobes got=we_bad %0d overlap %0d exp=0 0", we_bad, overlap);
        end
    endtask

    task automatic test_prog_err();
        int dc;
        nf_d_i = 8'h90;
        run_op(2'b01, 24'h000010, 8'hA5, 400, dc);
        checks++;
        if (pack_log() !== {4'd5, 9'h040, 9'h0A5, 9'h100, 9'h050, 9'h0FF}) begin
            failures++;
            $display("FAIL prog_err_seq got=%h exp=%h", pack_log(),
                     {4'd5, 9'h040, 9'h0A5, 9'h100, 9'h050, 9'h0FF});
        end
        checks++;
        if ({dc > 0, err} !== 2'b11) begin
            failures++;
            $display("FAIL prog_err_flag got=%0d/%b exp=done/1", dc, err);
        end
    endtask

    task automatic test_timeout();
        int dc;
        nf_d_i = 8'h80;
        sts_stuck = 1'b1;
        run_op(2'b01, 24'h000020, 8'h33, 400, dc);
        sts_stuck = 1'b0;
        checks++;
        if (pack_log() !== {4'd3, 9'h040, 9'h033, 9'h0FF, 9'h000, 9'h000}) begin
            failures++;
            $display("FAIL timeout_seq got=%h exp=%h", pack_log(),
                     {4'd3, 9'h040, 9'h033, 9'h0FF, 9'h000, 9'h000});
        end
        checks++;
        if ({dc, err} !== {32'(2*(WR_PULSE+3) + TO_CYC + (WR_PULSE+3) + 1), 1'b1}) begin
            failures++;
            $display("FAIL timeout_done got=%0d/%b exp=%0d/1", dc, err,
                     2*(WR_PULSE+3) + TO_CYC + (WR_PULSE+3) + 1);
        end
    endtask

    task automatic test_erase();
        int dc;
        nf_d_i = 8'h80;
`ifdef FLASH_ERASE_EN
        run_op(2'b10, 24'h010000, 8'h00, 400, dc);
        checks++;
        if (pack_log() !== {4'd4, 9'h020, 9'h0D0, 9'h100, 9'h0FF, 9'h000}) begin
            failures++;
            $display("FAIL erase_seq got=%h exp=%h", pack_log(),
                     {4'd4, 9'h020, 9'h0D0, 9'h100, 9'h0FF, 9'h000});
        end
        checks++;
        if ({dc > 0, err} !== 2'b10) begin
            failures++;
            $display("FAIL erase_done got=%0d/%b exp=done/0", dc, err);
        end
`else
        run_op(2'b10, 24'h010000, 8'h00, 10, dc);
        checks++;
        if ({dc, err, strobe_cycles, 4'(log_q.size())} !== {32'd1, 1'b1, 32'd0, 4'd0}) begin
            failures++;
            $display("FAIL erase_disabled got=%0d/%b/%0d/%0d exp=1/1/0/0",
                     dc, err, strobe_cycles, log_q.size());
        end
`endif
    endtask

    task automatic test_reserved();
        int dc;
        run_op(2'b11, 24'h000777, 8'h00, 10, dc);
        checks++;
        if ({dc, err, strobe_cycles} !== {32'd1, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL reserved got=%0d/%b/%0d exp=1/1/0", dc, err, strobe_cycles);
        end
    endtask

    task automatic test_abort();
        bit found;
        int dones, bk;
        found = 1'b0; dones = 0; bk = -1;
        @(negedge clk_f);
        cmd = 2'b01; addr = 24'h000040; wdata = 8'h77; req = 1'b1;
        @(negedge clk_f);
        req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!NF_WE) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_f);
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL abort_we_seen got=%b exp=1", found);
        end
        rst = 1'b1;
        @(negedge clk_f);
        checks++;
        if ({NF_CE, NF_OE, NF_WE, NF_D_OE, NF_RP, done, busy} !== 7'b1110001) begin
            failures++;
            $display("FAIL abort_state got=%b exp=1110001",
                     {NF_CE, NF_OE, NF_WE, NF_D_OE, NF_RP, done, busy});
        end
        @(negedge clk_f);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_f);
            if (done) dones++;
            if (!busy) begin
                bk = k;
                break;
            end
        end
        checks++;
        if ({bk, dones} !== {32'(1 + RP_WAIT), 32'd0}) begin
            failures++;
            $display("FAIL abort_restart got=%0d/%0d exp=%0d/0", bk, dones, 1 + RP_WAIT);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_read();
        test_req_ignore();
        test_program();
        test_prog_err();
        test_timeout();
        test_erase();
        test_reserved();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
